// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit serializer.
// BIT_SERIALIZER_PARITY_EN adds the PARITY state to the state encoding.
package serializer_pkg;

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  localparam logic PARITY_EVEN = 1'b0;

  function automatic int unsigned next_bit_idx(input int unsigned idx,
                                               input int unsigned modulus);
    return (idx >= modulus - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Modulo-WIDTH up-counter with synchronous clear and enable.
// `last` flags the final index of a frame.
module bit_counter
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = CW'(next_bit_idx(32'(cnt_q), WIDTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage with valid/ready load and gapless back-to-back frames.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             bit_valid,
  output logic             frame_done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             cnt_clr, cnt_en, cnt_last;
  logic             accept;

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

  // Ready depends on state only, so it never loops back through load_valid.
  always_comb begin
    load_ready = 1'b0;
    case (state_q)
      IDLE:    load_ready = 1'b1;
      SHIFT: begin
`ifdef BIT_SERIALIZER_PARITY_EN
        load_ready = 1'b0;
`else
        load_ready = cnt_last;
`endif
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY:  load_ready = 1'b1;
`endif
      default: load_ready = 1'b0;
    endcase
  end

  assign accept = load_valid && load_ready;

  // The register rotates rather than shifts, so after WIDTH bits it holds the word again.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    x          = 1'b0;
    bit_valid  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = data_in;
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bit_valid = 1'b1;
        cnt_en    = 1'b1;
        if (MSB_FIRST != 0) begin
          x       = shreg_q[WIDTH-1];
          shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
        end else begin
          x       = shreg_q[0];
          shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
        end
        if (cnt_last) begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          frame_done = 1'b1;
          if (accept) begin
            shreg_d = data_in;
            cnt_clr = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        x          = (^shreg_q) ^ PARITY_EVEN;
        bit_valid  = 1'b1;
        frame_done = 1'b1;
        if (accept) begin
          shreg_d = data_in;
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first and LSB-first instances share stimulus.
module tb_bit_serializer;

  localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = PAR ? W + 1 : W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;
  logic         lr_s [2];
  logic         x_s  [2];
  logic         bv_s [2];
  logic         fd_s [2];

  int tests = 0;
  int fails = 0;
  logic [1:0] exp_q [2][$];
  int run_len [2];
  int max_run [2];
  int done_cnt [2];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(lr_s[0]), .x(x_s[0]), .bit_valid(bv_s[0]), .frame_done(fd_s[0])
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(lr_s[1]), .x(x_s[1]), .bit_valid(bv_s[1]), .frame_done(fd_s[1])
  );

  task automatic check(input string name, input int k, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d at %0t: got %b expected %b", name, k, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: frame = data bits in wire order, then optional parity; done on the final bit.
  task automatic push_frame(input logic [W-1:0] w);
    logic bm, bl, par;
    par = logic'($countones(w) % 2);
    for (int i = 0; i < W; i++) begin
      bm = w[W-1-i];
      bl = w[i];
      exp_q[0].push_back({bm, (i == W - 1) && !PAR});
      exp_q[1].push_back({bl, (i == W - 1) && !PAR});
    end
    if (PAR) begin
      exp_q[0].push_back({par, 1'b1});
      exp_q[1].push_back({par, 1'b1});
    end
  endtask

  // Offers garbage with load_valid high while not ready, then the real word once ready.
  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    @(negedge clk);
    load_valid = 1'b1;
    while (!lr_s[0] && n < 100) begin
      data_in = W'($urandom);
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      fails++;
      tests++;
      $display("FAIL send_timeout at %0t: load_ready stayed 0", $time);
    end
    data_in = w;
    push_frame(w);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    data_in    = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL drain_timeout at %0t: %0d/%0d bits never appeared", $time,
               exp_q[0].size(), exp_q[1].size());
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      max_run[k]  = 0;
      done_cnt[k] = 0;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    for (int k = 0; k < 2; k++) begin
      check({name, "_x"}, k, x_s[k], 1'b0);
      check({name, "_bit_valid"}, k, bv_s[k], 1'b0);
      check({name, "_frame_done"}, k, fd_s[k], 1'b0);
      check({name, "_load_ready"}, k, lr_s[k], 1'b1);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (bv_s[k]) begin
          run_len[k]++;
          if (run_len[k] > max_run[k]) max_run[k] = run_len[k];
          if (fd_s[k]) done_cnt[k]++;
          if (exp_q[k].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_bit dut%0d at %0t: got x=%b with nothing expected",
                     k, $time, x_s[k]);
          end else begin
            e = exp_q[k].pop_front();
            check("serial_x", k, x_s[k], e[1]);
            check("frame_done", k, fd_s[k], e[0]);
          end
        end else begin
          run_len[k] = 0;
          check("idle_x", k, x_s[k], 1'b0);
          check("idle_frame_done", k, fd_s[k], 1'b0);
        end
      end
    end else begin
      run_len[0] = 0;
      run_len[1] = 0;
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) run_len[k] = 0;
    clear_stats();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single frame: A5 then idle.
    clear_stats();
    send(8'hA5);
    drain();
    check_int("a5_done_pulses_m", done_cnt[0], 1);
    check_int("a5_run_len_m", max_run[0], FRAME);

    // LSB-first reference vector (and parity 1 with the macro).
    send(8'h01);
    drain();
    send(8'h07);
    drain();

    // Back-to-back FF then 00: continuous bit_valid, two done pulses.
    clear_stats();
    send(8'hFF);
    send(8'h00);
    drain();
    check_int("b2b_run_len_m", max_run[0], 2 * FRAME);
    check_int("b2b_run_len_l", max_run[1], 2 * FRAME);
    check_int("b2b_done_pulses_m", done_cnt[0], 2);
    check_int("b2b_done_pulses_l", done_cnt[1], 2);

    // Abort mid-frame by reset, then recover with 0F.
    clear_stats();
    send(8'hA5);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_q[0].delete();
    exp_q[1].delete();
    @(negedge clk);
    rst = 1'b0;
    send(8'h0F);
    drain();
    check_int("abort_done_pulses_m", done_cnt[0], 1);
    check_int("abort_done_pulses_l", done_cnt[1], 1);

    // Random words with random gaps, some back-to-back.
    for (int t = 0; t < 40; t++) begin
      send(W'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
